// File: rtl/dual_rail_rx.sv
// Clocked receiver for a four-phase dual-rail link: synchronises the rails, acks each token,
// assembles WIDTH tokens LSB-first and presents the word on a valid/ready port.
module dual_rail_rx #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             bit0,
    input  logic             bit1,
    output logic             ack,
    output logic [WIDTH-1:0] data_out,
    output logic             data_valid,
    input  logic             data_ready,
    output logic             proto_err
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_RESYNC,
        ST_WAIT,
        ST_ACK
    } state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] sync0;
    logic [SYNC_STAGES-1:0] sync1;
    logic [SYNC_STAGES-1:0] primed;
    logic [CW-1:0]          bit_cnt;
    logic [WIDTH-1:0]       shift;
    logic                   r0;
    logic                   r1;
    logic                   primed_full;
    logic                   slot_free;

    assign r0          = sync0[SYNC_STAGES-1];
    assign r1          = sync1[SYNC_STAGES-1];
    assign primed_full = &primed;
    assign slot_free   = !data_valid || data_ready;

    // primed fills once the chains hold real pin samples, so the reset value of the
    // synchronisers is never mistaken for a SPACER when leaving RESYNC.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync0  <= '0;
            sync1  <= '0;
            primed <= '0;
        end else begin
            sync0  <= {sync0[SYNC_STAGES-2:0], bit0};
            sync1  <= {sync1[SYNC_STAGES-2:0], bit1};
            primed <= {primed[SYNC_STAGES-2:0], 1'b1};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= ST_RESYNC;
            ack        <= 1'b0;
            data_out   <= '0;
            data_valid <= 1'b0;
            proto_err  <= 1'b0;
            bit_cnt    <= '0;
            shift      <= '0;
        end else begin
            proto_err <= 1'b0;
            // A word loaded below overrides this clear on the same edge.
            if (data_valid && data_ready)
                data_valid <= 1'b0;
            case (state)
                ST_RESYNC: begin
                    ack <= 1'b0;
                    if (primed_full && !r0 && !r1)
                        state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (r0 && r1) begin
                        proto_err <= 1'b1;
                        bit_cnt   <= '0;
                        shift     <= '0;
                        state     <= ST_RESYNC;
                    end else if (r0 ^ r1) begin
                        if (bit_cnt != LAST) begin
                            shift[bit_cnt] <= r1;
                            bit_cnt        <= bit_cnt + 1'b1;
                            state          <= ST_ACK;
                            ack            <= 1'b1;
                        end else if (slot_free) begin
                            data_out   <= {r1, shift[WIDTH-2:0]};
                            data_valid <= 1'b1;
                            bit_cnt    <= '0;
                            state      <= ST_ACK;
                            ack        <= 1'b1;
                        end
                    end
                end
                ST_ACK: begin
                    if (!r0 && !r1) begin
                        state <= ST_WAIT;
                        ack   <= 1'b0;
                    end
                end
                default: begin
                    state <= ST_RESYNC;
                    ack   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dual_rail_rx.sv
// Directed bench for dual_rail_rx: acts as the four-phase sender and as the word consumer.
module tb_dual_rail_rx;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       bit0 = 1'b0;
    logic       bit1 = 1'b0;
    logic       data_ready = 1'b0;
    logic       ack;
    logic       data_valid;
    logic       proto_err;
    logic [7:0] data_out;

    int   total = 0;
    int   bad = 0;
    int   ack_rises = 0;
    logic dv_before;
    logic dv_at_rise;

    dual_rail_rx #(
        .WIDTH      (8),
        .SYNC_STAGES(2)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .bit0      (bit0),
        .bit1      (bit1),
        .ack       (ack),
        .data_out  (data_out),
        .data_valid(data_valid),
        .data_ready(data_ready),
        .proto_err (proto_err)
    );

    always #5 clk = ~clk;
    always @(posedge ack) ack_rises++;

    initial begin
        #1000000;
        total++;
        bad++;
        $display("FAIL watchdog observed=timeout expected=finish");
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Counts edges until ack reaches lvl; the sync path fixes this at 3 edges.
    task automatic wait_ack(input logic lvl, input string tag);
        int n;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (ack !== lvl && n < 40);
        chk({tag, "_lat"}, n, 3);
    endtask

    task automatic send_token(input logic v);
        @(posedge clk);
        #2;
        dv_before = data_valid;
        bit0 = ~v;
        bit1 = v;
        wait_ack(1'b1, "rise");
        dv_at_rise = data_valid;
        bit0 = 1'b0;
        bit1 = 1'b0;
        wait_ack(1'b0, "fall");
    endtask

    task automatic send_word(input logic [7:0] w);
        for (int i = 0; i < 8; i++) send_token(w[i]);
    endtask

    task automatic consume();
        @(posedge clk);
        #2;
        data_ready = 1'b1;
        @(posedge clk);
        #1;
        data_ready = 1'b0;
        chk("consume_dv", data_valid, 0);
    endtask

    task automatic count_high(input int cycles, output int n_ack, output int n_err);
        n_ack = 0;
        n_err = 0;
        repeat (cycles) begin
            @(posedge clk);
            #1;
            if (ack === 1'b1) n_ack++;
            if (proto_err === 1'b1) n_err++;
        end
    endtask

    initial begin
        int         a0;
        int         n_ack;
        int         n_err;
        logic [7:0] w2;
        logic [7:0] w6;

        // Reset state
        #12;
        chk("rst_ack", ack, 0);
        chk("rst_dv", data_valid, 0);
        chk("rst_dout", data_out, 0);
        chk("rst_perr", proto_err, 0);
        @(posedge clk);
        #2;
        reset = 1'b1;
        repeat (5) @(posedge clk);

        // 1: basic word, valid rises with the 8th ack
        a0 = ack_rises;
        send_word(8'h4D);
        chk("t1_dv_before_last", dv_before, 0);
        chk("t1_dv_at_last_ack", dv_at_rise, 1);
        chk("t1_dout", data_out, 8'h4D);
        chk("t1_ack_pulses", ack_rises - a0, 8);

        // 2: back-pressure on the final token of the second word
        consume();
        send_word(8'hA5);
        chk("t2_w1_dout", data_out, 8'hA5);
        chk("t2_w1_dv", data_valid, 1);
        w2 = 8'h3C;
        for (int i = 0; i < 7; i++) send_token(w2[i]);
        @(posedge clk);
        #2;
        bit0 = 1'b1;
        bit1 = 1'b0;
        count_high(10, n_ack, n_err);
        chk("t2_blocked_ack", n_ack, 0);
        chk("t2_hold_dout", data_out, 8'hA5);
        #1;
        data_ready = 1'b1;
        @(posedge clk);
        #1;
        data_ready = 1'b0;
        chk("t2_ack_on_accept", ack, 1);
        chk("t2_w2_dout", data_out, 8'h3C);
        chk("t2_w2_dv", data_valid, 1);
        bit0 = 1'b0;
        wait_ack(1'b0, "t2_fall");
        chk("t2_w2_stable", data_out, 8'h3C);

        // 3: illegal code mid-word
        consume();
        send_token(1'b1);
        send_token(1'b1);
        send_token(1'b0);
        @(posedge clk);
        #2;
        bit0 = 1'b1;
        bit1 = 1'b1;
        count_high(8, n_ack, n_err);
        chk("t3_perr_cycles", n_err, 1);
        chk("t3_ack_low", n_ack, 0);
        bit0 = 1'b0;
        bit1 = 1'b0;
        repeat (5) @(posedge clk);
        send_word(8'h96);
        chk("t3_dout", data_out, 8'h96);
        chk("t3_dv", data_valid, 1);

        // 4: reset released while a rail is high
        @(posedge clk);
        #2;
        reset = 1'b0;
        bit1 = 1'b1;
        @(posedge clk);
        #2;
        reset = 1'b1;
        count_high(10, n_ack, n_err);
        chk("t4_no_ack", n_ack, 0);
        chk("t4_dv", data_valid, 0);
        bit1 = 1'b0;
        repeat (5) @(posedge clk);
        send_word(8'h5A);
        chk("t4_dout", data_out, 8'h5A);

        // 5: async reset while acking token 5, word 5A still held
        w2 = 8'hC3;
        for (int i = 0; i < 4; i++) send_token(w2[i]);
        @(posedge clk);
        #2;
        bit1 = 1'b1;
        wait_ack(1'b1, "t5_rise");
        #1;
        reset = 1'b0;
        #1;
        chk("t5_ack", ack, 0);
        chk("t5_dv", data_valid, 0);
        chk("t5_dout", data_out, 0);
        bit1 = 1'b0;
        @(posedge clk);
        #2;
        reset = 1'b1;
        repeat (5) @(posedge clk);
        send_word(8'hC3);
        chk("t5_word", data_out, 8'hC3);
        chk("t5_word_dv", data_valid, 1);

        // 6: sub-cycle glitch and a rail swap while in ACK
        consume();
        a0 = ack_rises;
        @(posedge clk);
        #2;
        bit1 = 1'b1;
        #2;
        bit1 = 1'b0;
        count_high(8, n_ack, n_err);
        chk("t6_glitch_ack", n_ack, 0);
        @(posedge clk);
        #2;
        bit1 = 1'b1;
        wait_ack(1'b1, "t6_rise");
        bit1 = 1'b0;
        bit0 = 1'b1;
        count_high(6, n_ack, n_err);
        chk("t6_ack_held", n_ack, 6);
        chk("t6_swap_no_err", n_err, 0);
        bit0 = 1'b0;
        wait_ack(1'b0, "t6_fall");
        w6 = 8'hE7;
        for (int i = 1; i < 8; i++) send_token(w6[i]);
        chk("t6_dv_before_last", dv_before, 0);
        chk("t6_dv_at_last_ack", dv_at_rise, 1);
        chk("t6_dout", data_out, 8'hE7);
        chk("t6_ack_pulses", ack_rises - a0, 8);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
